// File: rtl/scaler_pkg.sv
// Shared parameters and types for the line-buffer scaler controller.
package scaler_pkg;
  localparam int ADDR_WIDTH = 11;
  localparam int DATA_WIDTH = 8;
  localparam int FRAC_BITS  = 8;
  localparam int LINE_MAX   = 1024;
  localparam int X_W        = 10;
  localparam int LEN_W      = 11;

  typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_DRAIN} rd_state_t;

  // A width field of zero encodes a full LINE_MAX line.
  function automatic logic [LEN_W-1:0] width_decode(input logic [X_W-1:0] w);
    return (w == '0) ? LEN_W'(LINE_MAX) : {1'b0, w};
  endfunction
endpackage

// File: rtl/scaler_out_fifo.sv
// Two-entry FIFO holding line-RAM read data plus its end-of-line tag.
module scaler_out_fifo
  import scaler_pkg::*;
#(
  parameter int DATA_WIDTH = scaler_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  output logic [1:0]            count
);
  logic [DATA_WIDTH-1:0] data_reg [2];
  logic                  last_reg [2];
  logic                  wr_ptr_reg, rd_ptr_reg;
  logic [1:0]            count_reg;
  logic                  pop;

  assign m_valid = (count_reg != 2'd0);
  assign m_data  = m_valid ? data_reg[rd_ptr_reg] : '0;
  assign m_last  = m_valid & last_reg[rd_ptr_reg];
  assign count   = count_reg;
  assign pop     = m_valid & m_ready;

  // The caller never pushes into a full FIFO, so no overflow guard is needed.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && wr_ptr_reg == 1'(gi)) begin
        data_reg[gi] <= push_data;
        last_reg[gi] <= push_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/scaler_line_ctrl.sv
// Ping-pong line buffer controller: stores input lines and replays them resampled by cfg_step.
module scaler_line_ctrl
  import scaler_pkg::*;
#(
  parameter int ADDR_WIDTH = scaler_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = scaler_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = scaler_pkg::FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            cfg_in_width,
  input  logic [9:0]            cfg_out_width,
  input  logic [15:0]           cfg_step,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH-1:0] ram_a_addr,
  output logic [DATA_WIDTH-1:0] ram_a_wr_data,
  output logic                  ram_a_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_b_addr,
  input  logic [DATA_WIDTH-1:0] ram_b_rd_data
);
  localparam int XA_W  = ADDR_WIDTH - 1;
  localparam int ACC_W = FRAC_BITS + X_W;

  logic             wr_bank_reg, rd_bank_reg;
  logic [1:0]       full_reg, full_next;
  logic [X_W-1:0]   wr_x_reg;
  logic [LEN_W-1:0] len_reg [2];
  rd_state_t        state_reg;
  logic [LEN_W-1:0] out_w_reg, rd_x_reg;
  logic [15:0]      step_reg;
  logic [ACC_W-1:0] acc_reg;
  logic             inflight_reg, inflight_last_reg;

  logic             wr_fire, line_end, rd_release, issue, pop, last_issue;
  logic [LEN_W-1:0] in_w, len_m1;
  logic [X_W-1:0]   src_x, rd_idx;
  logic [2:0]       occ;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_sat;
  logic [1:0]       fifo_count;

  assign s_ready       = !rst && !full_reg[wr_bank_reg];
  assign wr_fire       = s_valid & s_ready;
  assign in_w          = width_decode(cfg_in_width);
  assign line_end      = wr_fire & (s_last | ({1'b0, wr_x_reg} == in_w - 1'b1));
  assign ram_a_addr    = rst ? '0 : {wr_bank_reg, XA_W'(wr_x_reg)};
  assign ram_a_wr_data = s_data;
  assign ram_a_wr_en   = wr_fire;

  // Fill and release may land on the same edge; they always target different banks.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign full_next[gi] = (line_end && wr_bank_reg == 1'(gi)) ? 1'b1 :
                           (rd_release && rd_bank_reg == 1'(gi)) ? 1'b0 : full_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_reg <= 1'b0;
      wr_x_reg    <= '0;
      full_reg    <= 2'b00;
      len_reg[0]  <= '0;
      len_reg[1]  <= '0;
    end else begin
      full_reg <= full_next;
      if (wr_fire) begin
        if (line_end) begin
          len_reg[wr_bank_reg] <= LEN_W'(wr_x_reg) + 1'b1;
          wr_bank_reg          <= ~wr_bank_reg;
          wr_x_reg             <= '0;
        end else begin
          wr_x_reg <= wr_x_reg + 1'b1;
        end
      end
    end
  end

  assign pop        = m_valid & m_ready;
  assign rd_release = (state_reg == RD_DRAIN) & pop & m_last;
  assign len_m1     = len_reg[rd_bank_reg] - 1'b1;
  assign src_x      = acc_reg[ACC_W-1:FRAC_BITS];
  assign rd_idx     = ({1'b0, src_x} > len_m1) ? len_m1[X_W-1:0] : src_x;
  assign ram_b_addr = rst ? '0 : {rd_bank_reg, XA_W'(rd_idx)};
  assign acc_sum    = {1'b0, acc_reg} + (ACC_W+1)'(step_reg);
  assign acc_sat    = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];

  // Occupancy is counted after this cycle's pop so reads can stream at one per clock.
  assign occ        = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue      = (state_reg == RD_RUN) && (occ < 3'd2);
  assign last_issue = issue && (rd_x_reg == out_w_reg - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= RD_IDLE;
      rd_bank_reg       <= 1'b0;
      out_w_reg         <= '0;
      step_reg          <= '0;
      acc_reg           <= '0;
      rd_x_reg          <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      inflight_reg      <= issue;
      inflight_last_reg <= last_issue;
      case (state_reg)
        RD_IDLE: begin
          if (full_reg[rd_bank_reg]) begin
            state_reg <= RD_RUN;
            out_w_reg <= width_decode(cfg_out_width);
            step_reg  <= cfg_step;
            acc_reg   <= '0;
            rd_x_reg  <= '0;
          end
        end
        RD_RUN: begin
          if (issue) begin
            acc_reg  <= acc_sat;
            rd_x_reg <= rd_x_reg + 1'b1;
            if (last_issue) state_reg <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (rd_release) begin
            state_reg   <= RD_IDLE;
            rd_bank_reg <= ~rd_bank_reg;
          end
        end
        default: state_reg <= RD_IDLE;
      endcase
    end
  end

  scaler_out_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data (ram_b_rd_data),
    .push_last (inflight_last_reg),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_scaler_line_ctrl.sv
// Directed scoreboard bench for scaler_line_ctrl with a behavioural line RAM.
module tb_scaler_line_ctrl;
  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    cfg_in_width = '0, cfg_out_width = '0;
  logic [15:0]   cfg_step = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0, s_last = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last;
  logic          m_ready = 1'b0;
  logic [AW-1:0] ram_a_addr, ram_b_addr;
  logic [DW-1:0] ram_a_wr_data, ram_b_rd_data;
  logic          ram_a_wr_en;

  logic [DW-1:0] ram [2**AW];
  logic [DW:0]   exp_q [$];
  logic [DW-1:0] line_buf [1024];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  scaler_line_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_in_width(cfg_in_width), .cfg_out_width(cfg_out_width), .cfg_step(cfg_step),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .ram_a_addr(ram_a_addr), .ram_a_wr_data(ram_a_wr_data), .ram_a_wr_en(ram_a_wr_en),
    .ram_b_addr(ram_b_addr), .ram_b_rd_data(ram_b_rd_data)
  );

  always @(posedge clk) begin
    if (ram_a_wr_en) ram[ram_a_addr] <= ram_a_wr_data;
    ram_b_rd_data <= ram[ram_b_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Output monitor: every accepted pixel is matched against the scoreboard head.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!rst && m_valid && m_ready) begin
      $display("out data=%0h last=%0b", m_data, m_last);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL extra_pixel observed=%0h expected=none", m_data);
      end else begin
        e = exp_q.pop_front();
        check("m_data", 32'(m_data), 32'(e[DW-1:0]));
        check("m_last", 32'(m_last), 32'(e[DW]));
      end
    end
  end

  // Reference resampler: nearest-lower source pixel, clamped to the stored length.
  task automatic push_line(input int n_stored, input int out_w, input int step);
    int acc = 0;
    int idx;
    for (int k = 0; k < out_w; k++) begin
      idx = acc >> 8;
      if (idx > n_stored - 1) idx = n_stored - 1;
      exp_q.push_back({(k == out_w - 1), line_buf[idx]});
      acc += step;
      if (acc > 262143) acc = 262143;
    end
  endtask

  task automatic send_pix(input logic [DW-1:0] d, input logic l);
    int guard = 0;
    bit ok = 0;
    s_data = d; s_last = l; s_valid = 1'b1;
    do begin
      @(negedge clk); ok = s_ready;
      @(posedge clk); #1; guard++;
    end while (!ok && guard < 2000);
    if (!ok) begin
      checks++; errors++;
      $error("FAIL s_ready_timeout observed=0 expected=1");
    end else begin
      $display("in data=%0h last=%0b", d, l);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic load_line(input int base, input int n);
    for (int i = 0; i < n; i++) line_buf[i] = DW'(base + i);
  endtask

  task automatic send_line(input int n, input int last_at);
    for (int i = 0; i < n; i++) send_pix(line_buf[i], i == last_at);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(posedge clk); #1; guard++;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int in_w, input int out_w, input int step);
    cfg_in_width = 10'(in_w); cfg_out_width = 10'(out_w); cfg_step = 16'(step);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_wr_en", 32'(ram_a_wr_en), 32'd0);
    check("rst_a_addr", 32'(ram_a_addr), 32'd0);
    check("rst_b_addr", 32'(ram_b_addr), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;

    // Unity scale, plus first-output latency
    m_ready = 1'b1;
    set_cfg(8, 8, 16'h100);
    load_line(0, 8); push_line(8, 8, 16'h100); send_line(8, 7);
    repeat (3) @(negedge clk);
    check("latency_early_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("latency_first_valid", 32'(m_valid), 32'd1);
    wait_drain();

    // Downscale by 2
    set_cfg(8, 4, 16'h200);
    load_line(0, 8); push_line(8, 4, 16'h200); send_line(8, 7);
    wait_drain();

    // Upscale by 2
    set_cfg(4, 8, 16'h080);
    load_line(10, 4); push_line(4, 8, 16'h080); send_line(4, 3);
    wait_drain();

    // Early s_last shortens the line; reads clamp to the last stored pixel
    set_cfg(8, 4, 16'h200);
    load_line(0, 5); push_line(5, 4, 16'h200); send_line(5, 4);
    wait_drain();

    // Back-pressure across both banks, then release
    m_ready = 1'b0;
    set_cfg(8, 8, 16'h100);
    load_line(8'h20, 8); push_line(8, 8, 16'h100); send_line(8, 7);
    load_line(8'h40, 8); push_line(8, 8, 16'h100); send_line(8, 7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("both_full_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    load_line(8'h60, 8); push_line(8, 8, 16'h100); send_line(8, 7);
    wait_drain();

    // Reset mid-line while the reader is in RUN
    m_ready = 1'b0;
    load_line(8'h80, 8); send_line(8, 7);
    repeat (4) @(posedge clk);
    #1;
    load_line(8'h90, 3); send_line(3, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("mid_rst_s_ready", 32'(s_ready), 32'd1);
    check("mid_rst_a_addr", 32'(ram_a_addr), 32'd0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    set_cfg(8, 4, 16'h180);
    load_line(8'h50, 8); push_line(8, 4, 16'h180); send_line(8, 7);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
